// File: rtl/ps2_tx_multi.sv
// ps2_tx_multi
//
// Bank of CHANNELS independent PS/2 device-side transmitters. Each channel
// owns a byte FIFO of depth 2^FIFO_BITS. One free-running divider supplies the
// shared PS/2 clock phase for every channel. When the host pulls the clock
// line low (inhibit), a frame is aborted and the byte is retried after
// release. Each channel also has a flush strobe and a sticky overflow flag.
//
// Ports
//   clk_sys     system clock; all logic runs on its rising edge
//   reset       asynchronous, active-high; clears everything
//   wr          one-cycle push strobe
//   wr_chan     channel that receives wr_data; values >= CHANNELS are ignored
//   wr_data     byte to push
//   flush       per-channel flush strobe (FIFO and transmitter)
//   clear_ovf   per-channel strobe that clears overflow
//   ps2_clk_in  sensed host clock line per channel (0 = inhibit), asynchronous
//   ps2_clk     PS/2 clock output per channel
//   ps2_data    PS/2 data output per channel
//   busy        frame in progress (transmitter not idle)
//   empty       FIFO empty
//   full        FIFO full
//   overflow    sticky: a push to a full FIFO was dropped
//
// Handshake: wr is a fire-and-forget strobe with no ready. A byte is accepted
// when its channel is not full in that cycle. Otherwise it is dropped and
// overflow is set.
module ps2_tx_multi #(
    parameter int CHANNELS  = 2,
    parameter int FIFO_BITS = 3,
    parameter int PS2DIV    = 100
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                wr,
    input  logic [2:0]          wr_chan,
    input  logic [7:0]          wr_data,
    input  logic [CHANNELS-1:0] flush,
    input  logic [CHANNELS-1:0] clear_ovf,
    input  logic [CHANNELS-1:0] ps2_clk_in,
    output logic [CHANNELS-1:0] ps2_clk,
    output logic [CHANNELS-1:0] ps2_data,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] empty,
    output logic [CHANNELS-1:0] full,
    output logic [CHANNELS-1:0] overflow
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int CW    = (PS2DIV > 1) ? $clog2(PS2DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(PS2DIV - 1);

    // Transmitter states. States 1..8 shift out data bits.
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_PARITY = 4'd9;
    localparam logic [3:0] ST_STOP   = 4'd10;
    localparam logic [3:0] ST_DONE   = 4'd11;

    // Shared divider: clk_ps2 toggles every PS2DIV cycles.
    logic [CW-1:0] div_cnt;
    logic          clk_ps2;
    logic          rise;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            clk_ps2 <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            clk_ps2 <= ~clk_ps2;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // This is the cycle in which clk_ps2 goes from 0 to 1.
    assign rise = (div_cnt == DIV_LAST) && !clk_ps2;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        logic [7:0]           mem [DEPTH];
        logic [FIFO_BITS-1:0] wr_ptr;
        logic [FIFO_BITS-1:0] rd_ptr;
        logic [FIFO_BITS:0]   level;
        logic [3:0]           state;
        logic [7:0]           shreg;
        logic                 parity;
        logic                 data_q;
        logic                 ovf_q;
        logic [1:0]           sync_q;
        logic                 sel;
        logic                 is_full;
        logic                 is_empty;
        logic                 push;
        logic                 drop;
        logic                 pop;
        logic                 line_ok;

        assign sel      = wr && (wr_chan == 3'(ch));
        // Level never exceeds DEPTH, so its MSB alone marks full.
        assign is_full  = level[FIFO_BITS];
        assign is_empty = (level == '0);
        // A flush in the same cycle discards the byte without flagging overflow.
        assign push     = sel && !is_full && !flush[ch];
        assign drop     = sel &&  is_full && !flush[ch];
        assign line_ok  = sync_q[1];
        // The byte leaves the FIFO only when the stop bit goes out.
        assign pop      = rise && (state == ST_STOP) && line_ok && !flush[ch];

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                sync_q <= 2'b11;
            end else begin
                sync_q <= {sync_q[0], ps2_clk_in[ch]};
            end
        end

        always_ff @(posedge clk_sys) begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
            end
        end

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
                state  <= ST_IDLE;
                shreg  <= 8'h00;
                parity <= 1'b0;
                data_q <= 1'b1;
                ovf_q  <= 1'b0;
            end else begin
                // If a byte is dropped in the same cycle, the set overrides the clear.
                if (clear_ovf[ch]) begin
                    ovf_q <= 1'b0;
                end
                if (drop) begin
                    ovf_q <= 1'b1;
                end

                if (flush[ch]) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    level  <= '0;
                    state  <= ST_IDLE;
                    data_q <= 1'b1;
                end else begin
                    if (push) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                    if (push && !pop) begin
                        level <= level + 1'b1;
                    end else if (pop && !push) begin
                        level <= level - 1'b1;
                    end

                    if (rise) begin
                        if (state == ST_IDLE) begin
                            if (!is_empty && line_ok) begin
                                shreg  <= mem[rd_ptr];
                                data_q <= 1'b0;
                                parity <= 1'b1;
                                state  <= 4'd1;
                            end
                        end else if (state != ST_DONE && !line_ok) begin
                            // Host inhibit: abort. The byte stays queued for a retry.
                            state  <= ST_IDLE;
                            data_q <= 1'b1;
                        end else begin
                            case (state)
                                ST_PARITY: begin
                                    data_q <= parity;
                                    state  <= ST_STOP;
                                end
                                ST_STOP: begin
                                    data_q <= 1'b1;
                                    state  <= ST_DONE;
                                end
                                ST_DONE: begin
                                    state <= ST_IDLE;
                                end
                                default: begin
                                    // States 1..8 send LSB first.
                                    data_q <= shreg[0];
                                    parity <= parity ^ shreg[0];
                                    shreg  <= {1'b0, shreg[7:1]};
                                    state  <= state + 4'd1;
                                end
                            endcase
                        end
                    end
                end
            end
        end

        assign ps2_clk[ch]  = clk_ps2 | (state == ST_IDLE);
        assign ps2_data[ch] = data_q;
        assign busy[ch]     = (state != ST_IDLE);
        assign empty[ch]    = is_empty;
        assign full[ch]     = is_full;
        assign overflow[ch] = ovf_q;
    end

endmodule
